ldpc_encoder: RTL and testbench

LDPC_ENCODER -- requirements
Module: ldpc_encoder

---
 rtl/ldpc_encoder.sv | 171 +++++++++++++++++
 tb/tb_ldpc_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_encoder.sv
// Bit-serial systematic (12,4) LDPC encoder: one parity bit per cycle, registered codeword out.
// Optional syndrome self-check stage and chk_err port: define LDPC_ENC_SELFCHECK_EN.
module ldpc_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid,
    input  logic [3:0]  msg,
    output logic        busy,
    output logic [11:0] code,
    output logic        tx_en
`ifdef LDPC_ENC_SELFCHECK_EN
    ,
    output logic        chk_err
`endif
);

`ifdef LDPC_ENC_SELFCHECK_EN
    typedef enum logic [1:0] {IDLE, CALC, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  msg_q, msg_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  parity_q, parity_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        tx_en_q, tx_en_d;
    logic [11:0] code_q, code_d;
    logic        pbit;
    logic [11:0] cw;

    // parity_q[0..7] holds c3,c5,c6,c7,c8,c9,c10,c11
    assign cw = {parity_q[7:1], msg_q[3], parity_q[0], msg_q[2:0]};

    always_comb begin
        pbit = 1'b0;
        case (idx_q)
            3'd0: pbit = msg_q[2] ^ msg_q[1] ^ msg_q[0];
            3'd1: pbit = msg_q[2] ^ msg_q[1] ^ msg_q[0];
            3'd2: pbit = msg_q[2];
            3'd3: pbit = msg_q[3] ^ msg_q[2] ^ msg_q[1];
            3'd4: pbit = msg_q[3] ^ msg_q[2] ^ msg_q[1];
            3'd5: pbit = msg_q[0];
            3'd6: pbit = msg_q[2] ^ msg_q[0];
            3'd7: pbit = msg_q[3] ^ msg_q[2] ^ msg_q[1];
        endcase
    end

`ifdef LDPC_ENC_SELFCHECK_EN
    logic err_q, err_d;
    logic chk_err_q, chk_err_d;
    logic row_bit;

    always_comb begin
        row_bit = 1'b0;
        case (idx_q)
            3'd0: row_bit = cw[9] ^ cw[6] ^ cw[3] ^ cw[1];
            3'd1: row_bit = cw[10] ^ cw[6] ^ cw[0];
            3'd2: row_bit = cw[10] ^ cw[5] ^ cw[1];
            3'd3: row_bit = cw[8] ^ cw[7] ^ cw[6] ^ cw[2];
            3'd4: row_bit = cw[8] ^ cw[4] ^ cw[3] ^ cw[0];
            3'd5: row_bit = cw[11] ^ cw[7];
            3'd6: row_bit = cw[11] ^ cw[9] ^ cw[5] ^ cw[4];
            3'd7: row_bit = cw[10] ^ cw[9] ^ cw[2];
        endcase
    end
`endif

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        last_d   = last_q;
        busy_d   = busy_q;
        tx_en_d  = 1'b0;
        code_d   = code_q;
`ifdef LDPC_ENC_SELFCHECK_EN
        err_d     = err_q;
        chk_err_d = chk_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (msg_valid) begin
                    msg_d    = msg;
                    idx_d    = '0;
                    parity_d = '0;
                    last_d   = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
`ifdef LDPC_ENC_SELFCHECK_EN
                    err_d    = 1'b0;
`endif
                end
            end
            CALC: begin
                // last_q adds one settle cycle after c11, giving the 10-edge accept-to-tx_en latency
                if (last_q) begin
                    last_d = 1'b0;
                    idx_d  = '0;
`ifdef LDPC_ENC_SELFCHECK_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    parity_d[idx_q] = pbit;
                    idx_d           = idx_q + 3'd1;
                    last_d          = (idx_q == 3'd7);
                end
            end
`ifdef LDPC_ENC_SELFCHECK_EN
            CHECK: begin
                err_d = err_q | row_bit;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = DONE;
            end
`endif
            DONE: begin
                code_d  = cw;
                tx_en_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef LDPC_ENC_SELFCHECK_EN
                chk_err_d = err_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            msg_q    <= '0;
            idx_q    <= '0;
            parity_q <= '0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            tx_en_q  <= 1'b0;
            code_q   <= '0;
`ifdef LDPC_ENC_SELFCHECK_EN
            err_q     <= 1'b0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            tx_en_q  <= tx_en_d;
            code_q   <= code_d;
`ifdef LDPC_ENC_SELFCHECK_EN
            err_q     <= err_d;
            chk_err_q <= chk_err_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign tx_en = tx_en_q;
    assign code  = code_q;
`ifdef LDPC_ENC_SELFCHECK_EN
    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_ldpc_encoder.sv
// Self-checking bench for ldpc_encoder: vector table, scoreboard queue, reset/abort and streaming sequences.
module tb_ldpc_encoder;

`ifdef LDPC_ENC_SELFCHECK_EN
    localparam int LAT = 18;
    localparam int SP  = 19;
`else
    localparam int LAT = 10;
    localparam int SP  = 11;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        msg_valid = 1'b0;
    logic [3:0]  msg = 4'h0;
    logic        busy;
    logic [11:0] code;
    logic        tx_en;
`ifdef LDPC_ENC_SELFCHECK_EN
    logic        chk_err;
`endif

    ldpc_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg       (msg),
        .busy      (busy),
        .code      (code),
        .tx_en     (tx_en)
`ifdef LDPC_ENC_SELFCHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  m;
        logic [11:0] c;
    } vec_t;

    vec_t sb[$];
    int   tx_cycs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_tx = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] enc(input logic [3:0] m);
        logic [11:0] c;
        c[0]  = m[0];
        c[1]  = m[1];
        c[2]  = m[2];
        c[4]  = m[3];
        c[11] = m[3] ^ m[2] ^ m[1];
        c[8]  = c[11];
        c[7]  = c[11];
        c[10] = m[2] ^ m[0];
        c[9]  = m[0];
        c[6]  = m[2];
        c[5]  = m[2] ^ m[1] ^ m[0];
        c[3]  = c[5];
        return c;
    endfunction

    function automatic logic [7:0] syndrome(input logic [11:0] c);
        logic [7:0] s;
        s[0] = c[9] ^ c[6] ^ c[3] ^ c[1];
        s[1] = c[10] ^ c[6] ^ c[0];
        s[2] = c[10] ^ c[5] ^ c[1];
        s[3] = c[8] ^ c[7] ^ c[6] ^ c[2];
        s[4] = c[8] ^ c[4] ^ c[3] ^ c[0];
        s[5] = c[11] ^ c[7];
        s[6] = c[11] ^ c[9] ^ c[5] ^ c[4];
        s[7] = c[10] ^ c[9] ^ c[2];
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every tx_en pulse
    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            vec_t e;
            chk("tx_en_single_cycle", {31'd0, prev_tx}, 32'd0);
            tx_cycs.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_tx_en", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("code", {20'd0, code}, {20'd0, e.c});
                chk("decoded_msg", {28'd0, code[4], code[2], code[1], code[0]}, {28'd0, e.m});
                chk("syndrome", {24'd0, syndrome(code)}, 32'd0);
`ifdef LDPC_ENC_SELFCHECK_EN
                chk("chk_err", {31'd0, chk_err}, 32'd0);
`endif
            end
        end
        prev_tx = (tx_en === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full encode; extra msg_valid pulses with random msg arrive while busy and must be dropped
    task automatic encode(input logic [3:0] m, input logic [11:0] exp);
        int seen_at;
        seen_at = -1;
        msg = m;
        msg_valid = 1'b1;
        sb.push_back('{m: m, c: exp});
        tick();
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= LAT + 1; k++) begin
            msg = 4'($urandom);
            msg_valid = (k < 4);
            tick();
            if (tx_en === 1'b1 && seen_at < 0) seen_at = k;
        end
        chk("tx_latency", 32'(seen_at), 32'(LAT));
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vec_t tbl[4];
        int   seen;
        int   n0;
        logic [3:0] m;

        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   seen;
        int   n0;
        logic [3:0] m;

        tbl[0] = '{m: 4'hB, c: 12'h613};
        tbl[1] = '{m: 4'h0, c: 12'h000};
        tbl[2] = '{m: 4'h1, c: 12'h629};
        tbl[3] = '{m: 4'hF, c: 12'hBFF};

        // Reset with msg_valid high must not accept
        rst = 1'b1;
        msg_valid = 1'b1;
        msg = 4'hB;
        repeat (3) tick();
        rst = 1'b0;
        msg_valid = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_code", {20'd0, code}, 32'd0);
        chk("reset_tx_en", {31'd0, tx_en}, 32'd0);
`ifdef LDPC_ENC_SELFCHECK_EN
        chk("reset_chk_err", {31'd0, chk_err}, 32'd0);
`endif
        tick();
        chk("no_accept_in_reset", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 4; i++) encode(tbl[i].m, tbl[i].c);
        chk("code_held_after_done", {20'd0, code}, 32'hBFF);

        // Abort at CALC index 4: accept edge, 4 more edges, then reset edge
        encode(4'hB, 12'h613);
        msg = 4'h6;
        msg_valid = 1'b1;
        sb.push_back('{m: 4'h6, c: enc(4'h6)});
        tick();
        msg_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        msg_valid = 1'b1;
        msg = 4'h9;
        tick();
        rst = 1'b0;
        msg_valid = 1'b0;
        sb.delete();
        chk("abort_code", {20'd0, code}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_tx_en", {31'd0, tx_en}, 32'd0);
        seen = 0;
        for (int k = 0; k < SP + 2; k++) begin
            tick();
            if (tx_en === 1'b1) seen++;
        end
        chk("abort_no_tx", 32'(seen), 32'd0);
        encode(4'h6, enc(4'h6));

        // msg_valid held high, msg incrementing: accepts every SP edges
        n0 = tx_cycs.size();
        m = 4'h3;
        msg = m;
        msg_valid = 1'b1;
        for (int e = 0; e < 3 * SP; e++) begin
            if (e % SP == 0) sb.push_back('{m: msg, c: enc(msg)});
            tick();
            m = m + 4'h1;
            msg = m;
        end
        msg_valid = 1'b0;
        repeat (LAT + 2) tick();
        chk("stream_tx_count", 32'(tx_cycs.size() - n0), 32'd3);
        if (tx_cycs.size() - n0 == 3) begin
            chk("stream_spacing_1", 32'(tx_cycs[n0 + 1] - tx_cycs[n0]), 32'(SP));
            chk("stream_spacing_2", 32'(tx_cycs[n0 + 2] - tx_cycs[n0 + 1]), 32'(SP));
        end
        chk("stream_sb_empty", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 16; i++) encode(4'(i), enc(4'(i)));
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
